// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, keeps one request in flight
// to instruction memory and hands fetched words to decode over valid/ready.

`ifndef BRANCH_TYPE_BITS_COUNT
`define BRANCH_TYPE_BITS_COUNT 2
`endif
`ifndef BRANCH_TYPE_NONE
`define BRANCH_TYPE_NONE     2'd0
`endif
`ifndef BRANCH_TYPE_UNCOND
`define BRANCH_TYPE_UNCOND   2'd1
`endif
`ifndef BRANCH_TYPE_COND
`define BRANCH_TYPE_COND     2'd2
`endif
`ifndef BRANCH_TYPE_INDIRECT
`define BRANCH_TYPE_INDIRECT 2'd3
`endif
`ifndef PC_SRC_BITS_COUNT
`define PC_SRC_BITS_COUNT 2
`endif
`ifndef PC_SRC_PC_PLUS_4
`define PC_SRC_PC_PLUS_4     2'd0
`endif
`ifndef PC_SRC_PC_PLUS_IMM
`define PC_SRC_PC_PLUS_IMM   2'd1
`endif
`ifndef PC_SRC_GPR_PLUS_IMM
`define PC_SRC_GPR_PLUS_IMM  2'd2
`endif

module fetch_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ex_valid,
    input  logic [`BRANCH_TYPE_BITS_COUNT-1:0] branch_type,
    input  logic                               zero_flag,
    input  logic [XLEN-1:0]                    ex_pc,
    input  logic [XLEN-1:0]                    ex_imm,
    input  logic [XLEN-1:0]                    ex_gpr,
    output logic [`PC_SRC_BITS_COUNT-1:0]      pc_source,
    output logic                               flush,
    output logic                               imem_req,
    output logic [XLEN-1:0]                    imem_addr,
    input  logic                               imem_ready,
    input  logic                               imem_rvalid,
    input  logic [31:0]                        imem_rdata,
    output logic                               if_valid,
    output logic [XLEN-1:0]                    if_pc,
    output logic [31:0]                        if_instr,
    input  logic                               if_ready
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_OUT,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   if_pc_q, if_pc_d;
    logic [31:0]       if_instr_q, if_instr_d;

    logic              redirect;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   gpr_sum;

    // Next-PC selector for the EX instruction, decoded even when ex_valid is low.
    always_comb begin
        pc_source = 'x;
        case (branch_type)
            `BRANCH_TYPE_NONE:     pc_source = `PC_SRC_PC_PLUS_4;
            `BRANCH_TYPE_UNCOND:   pc_source = `PC_SRC_PC_PLUS_IMM;
            `BRANCH_TYPE_COND:     pc_source = zero_flag ? `PC_SRC_PC_PLUS_IMM
                                                         : `PC_SRC_PC_PLUS_4;
            `BRANCH_TYPE_INDIRECT: pc_source = `PC_SRC_GPR_PLUS_IMM;
            default:               pc_source = 'x;
        endcase
    end

    assign gpr_sum  = ex_gpr + ex_imm;
    assign redirect = ex_valid && (pc_source != `PC_SRC_PC_PLUS_4);
    assign flush    = redirect;

    // Indirect targets drop bit 0 so a jump can never land on an odd address.
    always_comb begin
        target = ex_pc + ex_imm;
        if (pc_source == `PC_SRC_GPR_PLUS_IMM) begin
            target = {gpr_sum[XLEN-1:1], 1'b0};
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;

        case (state_q)
            S_REQ: begin
                if (imem_ready) begin
                    if (redirect) begin
                        state_d = S_DRAIN;
                    end else begin
                        if_pc_d = pc_q;
                        pc_d    = pc_q + XLEN'(4);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (!redirect) begin
                        if_instr_d = imem_rdata;
                        state_d    = S_OUT;
                    end else begin
                        state_d = S_REQ;
                    end
                end else if (redirect) begin
                    state_d = S_DRAIN;
                end
            end
            S_OUT: begin
                if (redirect || if_ready) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // A redirect overrides any sequential PC update made above.
        if (redirect) begin
            pc_d = target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    assign imem_req  = rst_n && (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign if_valid  = rst_n && (state_q == S_OUT);
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, taken/untaken and
// indirect redirects, redirects in WAIT/OUT/REQ, decode stalls and reset in DRAIN.

module tb_fetch_sequencer;

    localparam logic [1:0] BT_NONE     = 2'd0;
    localparam logic [1:0] BT_UNCOND   = 2'd1;
    localparam logic [1:0] BT_COND     = 2'd2;
    localparam logic [1:0] BT_INDIRECT = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [1:0]  branch_type;
    logic        zero_flag;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_gpr;
    logic [1:0]  pc_source;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    int n_checks = 0;
    int n_errors = 0;

    int          mem_delay;
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_paddr;

    fetch_sequencer #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .branch_type (branch_type),
        .zero_flag   (zero_flag),
        .ex_pc       (ex_pc),
        .ex_imm      (ex_imm),
        .ex_gpr      (ex_gpr),
        .pc_source   (pc_source),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_ready    (if_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Instruction memory: accepts when imem_ready is high, answers mem_delay
    // cycles after the zero-wait slot, forgets everything on reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_pend    <= 1'b0;
            mem_cnt     <= 0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            imem_rvalid <= 1'b0;
            if (imem_req && imem_ready) begin
                if (mem_delay == 0) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_word(imem_addr);
                end else begin
                    mem_pend  <= 1'b1;
                    mem_cnt   <= mem_delay;
                    mem_paddr <= imem_addr;
                end
            end else if (mem_pend) begin
                if (mem_cnt == 1) begin
                    mem_pend    <= 1'b0;
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_word(mem_paddr);
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Entered and left on a settled REQ cycle; assumes zero-wait memory and if_ready high.
    task automatic fetch_one(input logic [31:0] a);
        check("req_high", imem_req, 1);
        check("req_addr", imem_addr, a);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        check("wait_req_low", imem_req, 0);
        check("wait_valid_low", if_valid, 0);
        @(negedge clk);
        #1;
        check("out_valid", if_valid, 1);
        check("out_pc", if_pc, a);
        check("out_instr", if_instr, mem_word(a));
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        ex_valid    = 1'b0;
        branch_type = BT_NONE;
        zero_flag   = 1'b0;
        ex_pc       = '0;
        ex_imm      = '0;
        ex_gpr      = '0;
        imem_ready  = 1'b1;
        if_ready    = 1'b1;
        mem_delay   = 0;

        // Reset and straight-line fetch
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_req_low", imem_req, 0);
        check("rst_valid_low", if_valid, 0);
        rst_n = 1'b1;
        #1;
        fetch_one(32'h100);
        fetch_one(32'h104);
        fetch_one(32'h108);

        // Taken conditional branch while a request is being accepted
        ex_valid    = 1'b1;
        branch_type = BT_COND;
        zero_flag   = 1'b1;
        ex_pc       = 32'h200;
        ex_imm      = 32'h40;
        #1;
        check("cond_taken_src", pc_source, 2'd1);
        check("cond_taken_flush", flush, 1);
        check("cond_taken_addr", imem_addr, 32'h10C);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        check("drain_req_low", imem_req, 0);
        check("drain_flush_low", flush, 0);
        check("drain_valid_low", if_valid, 0);
        @(negedge clk);
        #1;
        fetch_one(32'h240);

        // Untaken conditional branch
        ex_valid    = 1'b1;
        branch_type = BT_COND;
        zero_flag   = 1'b0;
        ex_pc       = 32'h244;
        ex_imm      = 32'h40;
        #1;
        check("cond_nt_src", pc_source, 2'd0);
        check("cond_nt_flush", flush, 0);
        fetch_one(32'h244);

        // Decode without ex_valid, then indirect jump with memory not ready
        ex_valid    = 1'b0;
        branch_type = BT_UNCOND;
        #1;
        check("novalid_src", pc_source, 2'd1);
        check("novalid_flush", flush, 0);
        imem_ready  = 1'b0;
        ex_valid    = 1'b1;
        branch_type = BT_INDIRECT;
        ex_gpr      = 32'h1003;
        ex_imm      = 32'h4;
        #1;
        check("ind_src", pc_source, 2'd2);
        check("ind_flush", flush, 1);
        check("ind_old_addr", imem_addr, 32'h248);
        @(negedge clk);
        ex_valid   = 1'b0;
        imem_ready = 1'b1;
        #1;
        fetch_one(32'h1006);

        // Redirect in WAIT with a slow response
        mem_delay = 3;
        #1;
        check("slow_req_addr", imem_addr, 32'h100A);
        @(negedge clk);
        ex_valid    = 1'b1;
        branch_type = BT_UNCOND;
        ex_pc       = 32'h300;
        ex_imm      = 32'h20;
        #1;
        check("wait_redir_flush", flush, 1);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        check("wdrain1_req_low", imem_req, 0);
        @(negedge clk);
        #1;
        check("wdrain2_req_low", imem_req, 0);
        @(negedge clk);
        mem_delay = 0;
        #1;
        check("stale_rvalid_req_low", imem_req, 0);
        check("stale_valid_low", if_valid, 0);
        @(negedge clk);
        #1;
        fetch_one(32'h320);

        // Decode stall for 5 cycles, then a redirect during the stall
        if_ready = 1'b0;
        #1;
        check("stall_req_addr", imem_addr, 32'h324);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("stall_valid", if_valid, 1);
            check("stall_pc", if_pc, 32'h324);
            check("stall_instr", if_instr, mem_word(32'h324));
            check("stall_req_low", imem_req, 0);
        end
        ex_valid    = 1'b1;
        branch_type = BT_UNCOND;
        ex_pc       = 32'h400;
        ex_imm      = 32'h10;
        #1;
        check("stall_redir_flush", flush, 1);
        @(negedge clk);
        ex_valid = 1'b0;
        if_ready = 1'b1;
        #1;
        check("post_stall_valid_low", if_valid, 0);
        check("post_stall_req", imem_req, 1);
        check("post_stall_addr", imem_addr, 32'h410);

        // Redirect into DRAIN, then a one-cycle reset
        mem_delay   = 3;
        ex_valid    = 1'b1;
        branch_type = BT_UNCOND;
        ex_pc       = 32'h500;
        ex_imm      = 32'h0;
        #1;
        check("drain_entry_flush", flush, 1);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        check("drain_hold_req_low", imem_req, 0);
        rst_n = 1'b0;
        #1;
        check("rst_drain_req_low", imem_req, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_delay = 0;
        #1;
        check("after_rst_req", imem_req, 1);
        check("after_rst_addr", imem_addr, 32'h100);
        check("after_rst_valid_low", if_valid, 0);
        fetch_one(32'h100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
